// File: rtl/mux_rr_n_pkg.sv
// Shared PHY TX definitions: default word width, channel limit, clog2 helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package mux_rr_n_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int MAX_NUM_CH     = 16;

  // Bits needed to encode values 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_rr_n_rr_arbiter.sv
// Rotate-priority arbiter with burst ownership: owner keeps the grant while
// requesting and under the burst limit, else cyclic search from last+1.
// Latency: combinational. Backpressure: none here, the caller gates the grant.
//
// Ports:
//   valid_in  - per-channel request
//   last      - owner of the current/most recent burst
//   burst_cnt - accepted words in the current burst (saturates at BURST_MAX)
//   grant     - one-hot grant, zero when nothing requests
//   grant_idx - encoded grant
//   grant_vld - some channel is granted
module rr_arbiter
  import mux_rr_n_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BURST_MAX = 4,
  parameter int CH_W      = clog2(NUM_CH),
  parameter int CNT_W     = clog2(BURST_MAX + 1)
) (
  input  logic [NUM_CH-1:0] valid_in,
  input  logic [CH_W-1:0]   last,
  input  logic [CNT_W-1:0]  burst_cnt,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_vld
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  logic [CH_W-1:0] cand;

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (valid_in[last] && (burst_cnt < BURST_LIM)) begin
      grant_idx = last;
      grant_vld = 1'b1;
    end else begin
      // Walk from the farthest candidate (last itself) down to last+1 so the
      // nearest requester after last overwrites everything behind it.
      for (int off = NUM_CH; off >= 1; off--) begin
        cand = CH_W'((int'(last) + off) % NUM_CH);
        if (valid_in[cand]) begin
          grant_idx = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign grant = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;

endmodule

// File: rtl/mux_rr_n.sv
// N-channel round-robin word mux with bounded bursts and source-channel tag.
// Latency: one cycle from accept to registered data_out/ch_out/valid_out.
// Backpressure: ready_out low with a held word drops all ready_in (combinational).
//
// Ports:
//   f2, reset_L          - clock, async active-low reset
//   data_in/valid_in     - NUM_CH packed words and requests
//   ready_in             - per-channel accept, at most one bit high
//   data_out/ch_out      - registered selected word and its source channel
//   valid_out/ready_out  - output handshake
module mux_rr_n
  import mux_rr_n_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  BURST_MAX  = 4,
  localparam int CH_W       = clog2(NUM_CH)
) (
  input  logic                         f2,
  input  logic                         reset_L,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            valid_in,
  output logic [NUM_CH-1:0]            ready_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [CH_W-1:0]              ch_out,
  output logic                         valid_out,
  input  logic                         ready_out
);

  localparam int               CNT_W     = clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  logic [CH_W-1:0]       last;
  logic [CNT_W-1:0]      burst_cnt;
  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       grant_idx;
  logic                  grant_vld;
  logic                  cap;
  logic                  accept;
  logic [DATA_WIDTH-1:0] ch_dat [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_split
    assign ch_dat[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_CH    (NUM_CH),
    .BURST_MAX (BURST_MAX),
    .CH_W      (CH_W),
    .CNT_W     (CNT_W)
  ) u_arb (
    .valid_in  (valid_in),
    .last      (last),
    .burst_cnt (burst_cnt),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Output slot is free this cycle if empty or being drained.
  assign cap      = !valid_out || ready_out;
  // Gated by reset_L so no source sees an accept while reset is asserted.
  assign ready_in = (reset_L && cap) ? grant : '0;
  assign accept   = reset_L && cap && grant_vld;

  always_ff @(posedge f2 or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      ch_out    <= '0;
      valid_out <= 1'b0;
      last      <= CH_W'(NUM_CH - 1);
      burst_cnt <= BURST_LIM;
    end else if (accept) begin
      data_out  <= ch_dat[grant_idx];
      ch_out    <= grant_idx;
      valid_out <= 1'b1;
      if (grant_idx == last) begin
        // Owner can be re-granted by the search after saturating; hold there.
        if (burst_cnt != BURST_LIM) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        last      <= grant_idx;
        burst_cnt <= CNT_W'(1);
      end
    end else if (cap) begin
      if (valid_out) valid_out <= 1'b0;
      // Owner went quiet: its burst is over, it must re-arbitrate on return.
      if (!valid_in[last]) burst_cnt <= BURST_LIM;
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
module tb_mux_rr_n;

  logic        f2;
  logic        reset_L;
  logic [31:0] data_in   [3];
  logic [3:0]  valid_in  [3];
  logic [3:0]  ready_in  [3];
  logic [7:0]  data_out  [3];
  logic [1:0]  ch_out    [3];
  logic        valid_out [3];
  logic        ready_out [3];

  int checks   = 0;
  int failures = 0;

  // Instance 0: BURST_MAX=1, instance 1: BURST_MAX=2, instance 2: BURST_MAX=4.
  mux_rr_n #(.NUM_CH(4), .DATA_WIDTH(8), .BURST_MAX(1)) dut0 (
    .f2(f2), .reset_L(reset_L), .data_in(data_in[0]), .valid_in(valid_in[0]),
    .ready_in(ready_in[0]), .data_out(data_out[0]), .ch_out(ch_out[0]),
    .valid_out(valid_out[0]), .ready_out(ready_out[0]));
  mux_rr_n #(.NUM_CH(4), .DATA_WIDTH(8), .BURST_MAX(2)) dut1 (
    .f2(f2), .reset_L(reset_L), .data_in(data_in[1]), .valid_in(valid_in[1]),
    .ready_in(ready_in[1]), .data_out(data_out[1]), .ch_out(ch_out[1]),
    .valid_out(valid_out[1]), .ready_out(ready_out[1]));
  mux_rr_n #(.NUM_CH(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut2 (
    .f2(f2), .reset_L(reset_L), .data_in(data_in[2]), .valid_in(valid_in[2]),
    .ready_in(ready_in[2]), .data_out(data_out[2]), .ch_out(ch_out[2]),
    .valid_out(valid_out[2]), .ready_out(ready_out[2]));

  initial f2 = 1'b0;
  always #5 f2 = ~f2;

  // Per-channel source queues and expected-output scoreboard {ch, data}.
  logic [7:0] src_q [4][$];
  logic [9:0] exp_q [$];
  int         nxt_src [4];
  int         nxt_exp [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      src_q[c].push_back(8'(c * 16 + nxt_src[c]));
      nxt_src[c]++;
    end
  endtask

  task automatic expect_ch(input int c);
    exp_q.push_back({2'(c), 8'(c * 16 + nxt_exp[c])});
    nxt_exp[c]++;
  endtask

  task automatic drive(input int inst, input int gap_ch);
    for (int c = 0; c < 4; c++) begin
      valid_in[inst][c]       = (src_q[c].size() > 0) && (c != gap_ch);
      data_in[inst][c*8 +: 8] = (src_q[c].size() > 0) ? src_q[c][0] : 8'h00;
    end
  endtask

  // Runs ncyc cycles starting just after a falling edge; consumes words from
  // the scoreboard as they leave the DUT.
  task automatic run(input int inst, input int ncyc, input int stall_at,
                     input int stall_len, input int gap_ch, input int gap_at);
    logic [7:0] hd;
    logic [1:0] hc;
    logic [3:0] acc;
    logic [9:0] e;
    hd = data_out[inst];
    hc = ch_out[inst];
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      ready_out[inst] = !(cyc >= stall_at && cyc < stall_at + stall_len);
      drive(inst, (cyc == gap_at) ? gap_ch : -1);
      #1;
      chk("onehot_ready_in", 32'($countones(ready_in[inst]) <= 1), 32'd1);
      if (!ready_out[inst] && valid_out[inst]) begin
        chk("stall_ready_in", 32'(ready_in[inst]), 32'd0);
        if (cyc > stall_at) begin
          chk("stall_data", 32'(data_out[inst]), 32'(hd));
          chk("stall_ch", 32'(ch_out[inst]), 32'(hc));
        end
      end
      if (valid_out[inst] && ready_out[inst]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'({ch_out[inst], data_out[inst]}), 32'h3ff);
        end else begin
          e = exp_q.pop_front();
          chk("sb_word", 32'({ch_out[inst], data_out[inst]}), 32'(e));
        end
      end
      acc = valid_in[inst] & ready_in[inst];
      @(posedge f2);
      #1;
      for (int c = 0; c < 4; c++) if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      hd = data_out[inst];
      hc = ch_out[inst];
      @(negedge f2);
    end
    ready_out[inst] = 1'b1;
    drive(inst, -1);
  endtask

  task automatic srcs_empty(input string tag);
    chk(tag, 32'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      data_in[i]   = 32'h0;
      valid_in[i]  = 4'hF;
      ready_out[i] = 1'b1;
    end
    for (int c = 0; c < 4; c++) begin
      nxt_src[c] = 0;
      nxt_exp[c] = 0;
    end
    reset_L = 1'b0;

    // Reset state, with requests present.
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("rst_data_out", 32'(data_out[i]), 32'd0);
      chk("rst_ch_out", 32'(ch_out[i]), 32'd0);
      chk("rst_valid_out", 32'(valid_out[i]), 32'd0);
      chk("rst_ready_in", 32'(ready_in[i]), 32'd0);
    end
    for (int i = 0; i < 3; i++) valid_in[i] = 4'h0;
    @(negedge f2);
    reset_L = 1'b1;

    // Single request on ch2 (BURST_MAX=4 instance).
    valid_in[2] = 4'b0100;
    data_in[2]  = 32'h005A_0000;
    #1;
    chk("single_ready_in", 32'(ready_in[2]), 32'b0100);
    @(posedge f2);
    #1;
    chk("single_data", 32'(data_out[2]), 32'h5A);
    chk("single_ch", 32'(ch_out[2]), 32'd2);
    chk("single_valid", 32'(valid_out[2]), 32'd1);
    valid_in[2] = 4'b0000;
    @(posedge f2);
    #1;
    chk("drain_valid", 32'(valid_out[2]), 32'd0);
    chk("drain_hold_data", 32'(data_out[2]), 32'h5A);
    @(negedge f2);

    // Full load, BURST_MAX=2: 0,0,1,1,2,2,3,3,0,0 at one word per cycle.
    load(0, 4); load(1, 2); load(2, 2); load(3, 2);
    expect_ch(0); expect_ch(0); expect_ch(1); expect_ch(1); expect_ch(2);
    expect_ch(2); expect_ch(3); expect_ch(3); expect_ch(0); expect_ch(0);
    run(1, 10, -1, 0, -1, -1);
    srcs_empty("full_throughput");
    run(1, 2, -1, 0, -1, -1);
    chk("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // Wrap, BURST_MAX=1: ch1/ch3 alternate with no bubbles.
    load(1, 2); load(3, 2);
    expect_ch(1); expect_ch(3); expect_ch(1); expect_ch(3);
    run(0, 4, -1, 0, -1, -1);
    srcs_empty("wrap_throughput");
    run(0, 2, -1, 0, -1, -1);
    chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure, BURST_MAX=2: 3-cycle stall mid-stream.
    load(2, 3); load(3, 3);
    expect_ch(2); expect_ch(2); expect_ch(3); expect_ch(3); expect_ch(2); expect_ch(3);
    run(1, 12, 2, 3, -1, -1);
    srcs_empty("bp_srcs");
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Burst end, BURST_MAX=4: ch0 one word, gap, ch1 burst of 4, then ch0.
    load(0, 3); load(1, 4);
    expect_ch(0); expect_ch(1); expect_ch(1); expect_ch(1); expect_ch(1);
    expect_ch(0); expect_ch(0);
    run(2, 9, -1, 0, 0, 1);
    srcs_empty("burst_srcs");
    chk("burst_sb_empty", 32'(exp_q.size()), 32'd0);

    // Async reset while holding a ch3 word.
    valid_in[0]    = 4'b1000;
    data_in[0]     = 32'h3C00_0000;
    ready_out[0]   = 1'b0;
    @(posedge f2);
    #1;
    chk("pre_rst_ch", 32'(ch_out[0]), 32'd3);
    chk("pre_rst_valid", 32'(valid_out[0]), 32'd1);
    valid_in[0] = 4'b1001;
    data_in[0]  = 32'h3C00_00A0;
    @(negedge f2);
    #2;
    reset_L = 1'b0;
    #1;
    chk("arst_data", 32'(data_out[0]), 32'd0);
    chk("arst_ch", 32'(ch_out[0]), 32'd0);
    chk("arst_valid", 32'(valid_out[0]), 32'd0);
    chk("arst_ready_in", 32'(ready_in[0]), 32'd0);
    @(negedge f2);
    reset_L = 1'b1;
    @(posedge f2);
    #1;
    chk("post_rst_ch", 32'(ch_out[0]), 32'd0);
    chk("post_rst_data", 32'(data_out[0]), 32'hA0);
    chk("post_rst_valid", 32'(valid_out[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-channel round-robin multiplexer for the PHY TX datapath. It generalises the two-input valid-arbitrated byte mux to NUM_CH channels and DATA_WIDTH bits. It adds per-channel ready backpressure, downstream ready, source-channel tagging and bounded burst ownership. It sits between the per-lane byte sources and the serialiser.

## Interface
Parameters:
- NUM_CH, 4, number of input channels (2..16); CH_W = clog2(NUM_CH) is derived locally.
- DATA_WIDTH, 8, width of each data word.
- BURST_MAX, 4, maximum consecutive accepted transfers from one channel before rotation (≥1; 1 = pure round-robin).

Ports:
- f2  input  1  clock; all state updates on its rising edge.
- reset_L  input  1  reset, asynchronous, active-low.
- data_in  input  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in  input  NUM_CH  per-channel request.
- ready_in  output  NUM_CH  per-channel accept (combinational).
- data_out  output  DATA_WIDTH  registered selected word.
- ch_out  output  CH_W  registered source channel of data_out.
- valid_out  output  1  data_out holds a word.
- ready_out  input  1  downstream accepts data_out this cycle.

## Operation
- Channel i is accepted when valid_in[i] && ready_in[i] (an "accept").
- ready_in[i] = grant[i] && (!valid_out || ready_out); at most one bit of ready_in is high.
- State: last (CH_W, owner of the current/most recent burst) and burst_cnt (clog2(BURST_MAX+1) bits, saturating at BURST_MAX).
- Grant, combinational:
  - If valid_in[last] && burst_cnt < BURST_MAX, grant = last.
  - Otherwise grant = the first i with valid_in[i], searching cyclically from last+1 (NUM_CH-1 wraps to 0) and ending at last inclusive.
  - No requests gives no grant.
- On accept from channel g:
  - Output register: data_out <= data_in[g], ch_out <= g, valid_out <= 1.
  - Burst state: if g == last then burst_cnt <= burst_cnt+1, else last <= g and burst_cnt <= 1.
- Capacity with no accept: if valid_out && ready_out, then valid_out <= 0, and data_out/ch_out hold their values.
- Stall: if valid_out && !ready_out, data_out/ch_out/valid_out hold, ready_in = 0 and burst state holds.
- Burst termination: in a cycle with capacity (!valid_out || ready_out) where valid_in[last] == 0, burst_cnt <= BURST_MAX. A returning owner therefore re-arbitrates.
- Reset values: data_out = 0, ch_out = 0, valid_out = 0, last = NUM_CH-1, burst_cnt = BURST_MAX. Channel 0 therefore has first priority after reset. ready_in = 0 while reset_L is low.
- Reset mid-operation:
  - Outputs clear immediately, without waiting for an f2 edge.
  - A held word is discarded.
  - valid_in must be re-sampled after release.

## Timing
- Latency: accept at edge k gives valid_out/data_out at edge k (registered); the word is visible the cycle after ready_in is high.
- Throughput: one word per cycle while ready_out = 1; no bubble on channel switch.
- ready_out → ready_in is a combinational path.
- Sources must hold data_in[i]/valid_in[i] stable until accepted.
- Simultaneous events:
  - Owner still requesting and under BURST_MAX always beats other requesters.
  - Capacity freed and new accept in the same cycle gives back-to-back output with valid_out staying 1.
- Reset release: the first accept is possible on the first f2 edge after reset_L goes high.

## Structure
- Shared header phy_tx_defs: default DATA_WIDTH, clog2 function, maximum NUM_CH.
- Sub-module rr_arbiter: combinational rotate-priority grant from valid_in, last, burst_cnt and BURST_MAX, producing a one-hot grant and an encoded index.
- mux_rr_n holds the output register, burst state and ready generation.

## Test plan
All scenarios use NUM_CH = 4 and DATA_WIDTH = 8; BURST_MAX is set per scenario.
- Single request: valid_in = 4'b0100, ch2 data 0x5A, ready_out = 1 → ready_in = 4'b0100; next edge data_out = 0x5A, ch_out = 2, valid_out = 1.
- Full load, BURST_MAX = 2, all channels valid, ready_out = 1 → ch_out sequence 0,0,1,1,2,2,3,3,0,0.
- Wrap, BURST_MAX = 1: only ch1 and ch3 valid → ch_out alternates 1,3,1,3, with no stalls.
- Backpressure: ready_out = 0 for 3 cycles while valid_out = 1 → data_out/ch_out stable and ready_in = 0. On release, the stream resumes with no lost or duplicated words (scoreboard by channel).
- Burst end, BURST_MAX = 4: ch0 sends 1 word then drops valid_in[0] for one cycle while ch1 is waiting → ch1 granted next. ch0 is served only after ch1's burst.
- Async reset while valid_out = 1, ch_out = 3: pull reset_L low between edges → data_out = 0, ch_out = 0, valid_out = 0, ready_in = 0 immediately. After release, ch0 wins over ch3.
